// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier and restoring divider with fixed latency.
// Stalls the core from issue until the one-cycle done pulse.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic               qneg;
  logic               rneg;
  logic               dz;

  logic             is_div;
  logic             is_sdiv;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign is_div  = (op_q == 2'b01) || (op_q == 2'b10);
  assign is_sdiv = (op_q == 2'b10);
  assign acc_hi  = acc[2*WIDTH-1:WIDTH];
  assign acc_lo  = acc[WIDTH-1:0];
  assign a_mag   = a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
  assign b_mag   = b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, b_q};

  // Negation wraps, so the most-negative quotient stays as-is.
  assign q_fix = qneg ? (~acc_lo + 1'b1) : acc_lo;
  assign r_fix = rneg ? (~acc_hi + 1'b1) : acc_hi;

  assign stall = busy | (start & (state == IDLE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q        <= op;
            a_q         <= src_a;
            b_q         <= src_b;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= PREP;
          end
        end
        PREP: begin
          cnt  <= '0;
          dz   <= is_div && (b_q == '0);
          qneg <= is_sdiv && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg <= is_sdiv && a_q[WIDTH-1];
          if (is_sdiv) begin
            acc <= {{WIDTH{1'b0}}, a_mag};
            b_q <= b_mag;
          end else begin
            acc <= {{WIDTH{1'b0}}, a_q};
          end
          state <= ITER;
        end
        ITER: begin
          if (!is_div) begin
            acc <= {mul_sum, acc_lo[WIDTH-1:1]};
          end else if (div_trial[WIDTH]) begin
            acc <= {div_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
          end else begin
            acc <= {div_trial[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (dz) begin
            result_lo   <= '1;
            result_hi   <= a_q;
            div_by_zero <= 1'b1;
          end else if (is_sdiv) begin
            result_lo <= q_fix;
            result_hi <= r_fix;
          end else begin
            result_lo <= acc_lo;
            result_hi <= acc_hi;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
